// File: rtl/qed_dup_controller_pkg.sv
// Shared definitions for the SQED duplicate-phase controller: FSM state
// encodings and default sizing for the original/duplicate counters.
package qed_dup_controller_pkg;

  localparam int QED_DEPTH_DEF        = 16;
  localparam int QED_CNT_W_DEF        = 5;
  localparam int QED_DRAIN_CYCLES_DEF = 5;

  typedef enum logic [2:0] {
    QED_ST_IDLE  = 3'd0,
    QED_ST_ORIG  = 3'd1,
    QED_ST_DUP   = 3'd2,
    QED_ST_DRAIN = 3'd3,
    QED_ST_DONE  = 3'd4
  } qed_state_e;

endpackage

// File: rtl/qed_dup_controller_drain_timer.sv
// Drain timer: loads a fixed cycle count, counts down every cycle without
// regard to pipeline stalls, and flags the last cycle of the window (count==1).
module qed_drain_timer #(
  parameter int CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  output logic done
);

  localparam int W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

  logic [W-1:0] count;

  // Down-counter: clear wins over load, load wins over decrement; parks at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= W'(CYCLES);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/qed_dup_controller.sv
// SQED phase sequencer: counts originals fetched, switches the QED front end
// into duplicate mode, counts replayed duplicates, holds fetch while the
// pipeline drains and then pulses qed_ready for the property checker.
module qed_dup_controller
  import qed_dup_controller_pkg::*;
#(
  parameter int DEPTH        = QED_DEPTH_DEF,
  parameter int CNT_W        = QED_CNT_W_DEF,
  parameter int DRAIN_CYCLES = QED_DRAIN_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             if_fire,
  input  logic             vld_out,
  input  logic             switch_req,
  output logic             exec_dup,
  output logic             fetch_hold,
  output logic             qed_ready,
  output logic             err_replay,
  output logic [CNT_W-1:0] orig_cnt,
  output logic [CNT_W-1:0] dup_cnt,
  output logic [2:0]       state
);

  qed_state_e state_q;

  logic cnt_full;
  logic dup_caught;
  logic fire_ok;
  logic violation;
  logic go_dup;
  logic dup_last;
  logic timer_load;
  logic timer_clr;
  logic timer_done;

  assign cnt_full   = (orig_cnt == CNT_W'(DEPTH));
  assign dup_caught = (dup_cnt == orig_cnt);
  assign fire_ok    = if_fire & ~fetch_hold;
  assign violation  = if_fire & fetch_hold;
  assign go_dup     = (switch_req & ((orig_cnt != '0) | fire_ok)) | cnt_full;
  assign dup_last   = ((dup_cnt + CNT_W'(fire_ok)) == orig_cnt);
  assign timer_load = (state_q == QED_ST_DUP) & ena & dup_last;
  assign timer_clr  = ~ena;
  assign state      = state_q;

  // Fetch is held when originals are full, duplicates have caught up, or while draining.
  always_comb begin
    fetch_hold = 1'b0;
    case (state_q)
      QED_ST_IDLE:  fetch_hold = 1'b0;
      QED_ST_ORIG:  fetch_hold = cnt_full;
      QED_ST_DUP:   fetch_hold = dup_caught;
      QED_ST_DRAIN: fetch_hold = 1'b1;
      QED_ST_DONE:  fetch_hold = 1'b1;
      default:      fetch_hold = 1'b0;
    endcase
  end

  // Phase FSM with counters and registered exec_dup/qed_ready; ena low aborts the phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= QED_ST_IDLE;
      exec_dup  <= 1'b0;
      qed_ready <= 1'b0;
      orig_cnt  <= '0;
      dup_cnt   <= '0;
    end else if ((state_q != QED_ST_IDLE) && !ena) begin
      state_q   <= QED_ST_IDLE;
      exec_dup  <= 1'b0;
      qed_ready <= 1'b0;
      orig_cnt  <= '0;
      dup_cnt   <= '0;
    end else begin
      qed_ready <= 1'b0;
      case (state_q)
        QED_ST_IDLE: begin
          orig_cnt <= '0;
          dup_cnt  <= '0;
          if (ena) begin
            state_q <= QED_ST_ORIG;
          end
        end
        QED_ST_ORIG: begin
          if (fire_ok && !cnt_full) begin
            orig_cnt <= orig_cnt + 1'b1;
          end
          if (go_dup) begin
            state_q  <= QED_ST_DUP;
            exec_dup <= 1'b1;
          end
        end
        QED_ST_DUP: begin
          if (fire_ok && (dup_cnt != CNT_W'(DEPTH))) begin
            dup_cnt <= dup_cnt + 1'b1;
          end
          if (dup_last) begin
            state_q  <= QED_ST_DRAIN;
            exec_dup <= 1'b0;
          end
        end
        QED_ST_DRAIN: begin
          if (timer_done) begin
            state_q   <= QED_ST_DONE;
            qed_ready <= 1'b1;
          end
        end
        QED_ST_DONE: begin
          orig_cnt <= '0;
          dup_cnt  <= '0;
          state_q  <= QED_ST_ORIG;
        end
        default: begin
          state_q  <= QED_ST_IDLE;
          exec_dup <= 1'b0;
          orig_cnt <= '0;
          dup_cnt  <= '0;
        end
      endcase
    end
  end

  // Sticky error: fetch while held, or a duplicate fetched with no valid replay entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_replay <= 1'b0;
    end else if (violation || ((state_q == QED_ST_DUP) && fire_ok && !vld_out)) begin
      err_replay <= 1'b1;
    end
  end

  qed_drain_timer #(
    .CYCLES (DRAIN_CYCLES)
  ) u_drain_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .load (timer_load),
    .done (timer_done)
  );

endmodule

// File: tb/tb_qed_dup_controller.sv
// Directed bench for qed_dup_controller: walks a full phase, the auto-switch
// at DEPTH, replay errors, ena abort during drain and an async reset mid-DUP.
module tb_qed_dup_controller;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;
  localparam int DRAIN = 5;

  localparam logic [31:0] S_IDLE  = 32'd0;
  localparam logic [31:0] S_ORIG  = 32'd1;
  localparam logic [31:0] S_DUP   = 32'd2;
  localparam logic [31:0] S_DRAIN = 32'd3;
  localparam logic [31:0] S_DONE  = 32'd4;

  logic             clk;
  logic             rst;
  logic             ena;
  logic             if_fire;
  logic             vld_out;
  logic             switch_req;
  logic             exec_dup;
  logic             fetch_hold;
  logic             qed_ready;
  logic             err_replay;
  logic [CNT_W-1:0] orig_cnt;
  logic [CNT_W-1:0] dup_cnt;
  logic [2:0]       state;

  int vectors;
  int miscompares;

  qed_dup_controller #(
    .DEPTH        (DEPTH),
    .CNT_W        (CNT_W),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .if_fire    (if_fire),
    .vld_out    (vld_out),
    .switch_req (switch_req),
    .exec_dup   (exec_dup),
    .fetch_hold (fetch_hold),
    .qed_ready  (qed_ready),
    .err_replay (err_replay),
    .orig_cnt   (orig_cnt),
    .dup_cnt    (dup_cnt),
    .state      (state)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic fire, input logic vld, input logic sw);
    if_fire    = fire;
    vld_out    = vld;
    switch_req = sw;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] st, input logic [31:0] ex,
                          input logic [31:0] rdy, input logic [31:0] err, input logic [31:0] oc,
                          input logic [31:0] dc, input logic [31:0] hold);
    checkOutput({tag, ".state"},      32'(state),      st);
    checkOutput({tag, ".exec_dup"},   32'(exec_dup),   ex);
    checkOutput({tag, ".qed_ready"},  32'(qed_ready),  rdy);
    checkOutput({tag, ".err_replay"}, 32'(err_replay), err);
    checkOutput({tag, ".orig_cnt"},   32'(orig_cnt),   oc);
    checkOutput({tag, ".dup_cnt"},    32'(dup_cnt),    dc);
    checkOutput({tag, ".fetch_hold"}, 32'(fetch_hold), hold);
  endtask

  // Directed sequence of all scenarios.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    ena = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkAll("reset", S_IDLE, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    $display("[TB] full phase with switch_req");
    ena = 1'b1;
    tick();
    checkAll("p2.enter", S_ORIG, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkOutput("p2.orig_cnt", 32'(orig_cnt), 32'(i));
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    checkAll("p2.switch", S_DUP, 1, 0, 0, 3, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkAll("p2.dup1", S_DUP, 1, 0, 0, 3, 1, 0);
    tick();
    checkAll("p2.dup2", S_DUP, 1, 0, 0, 3, 2, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkAll("p2.dup3", S_DRAIN, 0, 0, 0, 3, 3, 1);
    for (int i = 0; i < DRAIN - 1; i++) begin
      tick();
      checkOutput("p2.drain.state", 32'(state), S_DRAIN);
      checkOutput("p2.drain.ready", 32'(qed_ready), 0);
    end
    tick();
    checkAll("p2.done", S_DONE, 0, 1, 0, 3, 3, 1);
    tick();
    checkAll("p2.next", S_ORIG, 0, 0, 0, 0, 0, 0);

    $display("[TB] switch_req with empty count, then replay error");
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    checkAll("p6.noswitch", S_ORIG, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    checkAll("p6.switch", S_DUP, 1, 0, 0, 1, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkAll("p4.badreplay", S_DRAIN, 0, 0, 1, 1, 1, 1);

    $display("[TB] ena dropped during drain");
    ena = 1'b0;
    tick();
    checkAll("p5.abort", S_IDLE, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < DRAIN + 2; i++) begin
      tick();
      checkOutput("p5.noready", 32'(qed_ready), 0);
      checkOutput("p5.errsticky", 32'(err_replay), 1);
    end

    $display("[TB] async reset mid-DUP");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ena = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkAll("p1.pre", S_DUP, 1, 0, 0, 3, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    checkAll("p1.async", S_IDLE, 0, 0, 0, 0, 0, 0);
    ena = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checkAll("p1.after", S_IDLE, 0, 0, 0, 0, 0, 0);

    $display("[TB] fill to DEPTH without switch_req");
    ena = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      checkOutput("p3.fill", 32'(orig_cnt), 32'(i));
    end
    checkAll("p3.full", S_ORIG, 0, 0, 0, DEPTH, 0, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkAll("p3.autodup", S_DUP, 1, 0, 1, DEPTH, 0, 0);

    ena = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
